// File: rtl/pll_ddr_ctrl.sv
// PLL bring-up sequencer: reset pulse, lock wait, lock settle, staggered enclk enables, lock-loss recovery.
// Optional macro PLL_DDR_CTRL_RETRY_EN: lock timeouts retry twice before giving up.
module pll_ddr_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYCLES = 256,
    parameter int EN_GAP        = 8
) (
    input  logic       clkin,
    input  logic       resetn,
    input  logic       start,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [2:0] enclk,
    output logic       ready,
    output logic       fail,
    output logic [7:0] relock_cnt
);

    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (SETTLE_CYCLES > EN_GAP) ? SETTLE_CYCLES : EN_GAP;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(EN_GAP - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RESET     = 3'd1;
    localparam logic [2:0] WAIT_LOCK = 3'd2;
    localparam logic [2:0] SETTLE    = 3'd3;
    localparam logic [2:0] ENABLE    = 3'd4;
    localparam logic [2:0] RUN       = 3'd5;
    localparam logic [2:0] FAULT     = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          lock_m;
    logic          lock_s;

`ifdef PLL_DDR_CTRL_RETRY_EN
    logic [1:0] retry;
    logic       timeout;

    assign timeout = start && (state == WAIT_LOCK) && !lock_s && (cnt == TO_LAST);

    // Only consulted in WAIT_LOCK, so clearing while in IDLE/RUN is equivalent to clearing on entry.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            retry <= 2'd0;
        end else if (state == IDLE || state == RUN) begin
            retry <= 2'd0;
        end else if (timeout) begin
            retry <= retry + 2'd1;
        end
    end
`endif

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            lock_m     <= 1'b0;
            lock_s     <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            pll_reset  <= 1'b1;
            enclk      <= 3'b000;
            ready      <= 1'b0;
            fail       <= 1'b0;
            relock_cnt <= 8'd0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
            // Dropping start wins over every other event, including a simultaneous lock loss.
            if (state != FAULT && !start) begin
                state     <= IDLE;
                cnt       <= '0;
                pll_reset <= 1'b1;
                enclk     <= 3'b000;
                ready     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= RESET;
                        cnt   <= '0;
                    end
                    RESET: begin
                        if (cnt == RST_LAST) begin
                            state     <= WAIT_LOCK;
                            cnt       <= '0;
                            pll_reset <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= SETTLE;
                            cnt   <= '0;
                        end else if (cnt == TO_LAST) begin
                            cnt       <= '0;
                            pll_reset <= 1'b1;
`ifdef PLL_DDR_CTRL_RETRY_EN
                            if (retry == 2'd2) begin
                                state <= FAULT;
                                fail  <= 1'b1;
                            end else begin
                                state <= RESET;
                            end
`else
                            state <= FAULT;
                            fail  <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    SETTLE: begin
                        if (!lock_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == SET_LAST) begin
                            state <= ENABLE;
                            cnt   <= '0;
                            enclk <= 3'b001;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ENABLE: begin
                        if (!lock_s) begin
                            state     <= RESET;
                            cnt       <= '0;
                            enclk     <= 3'b000;
                            pll_reset <= 1'b1;
                        end else if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            if (enclk[1]) begin
                                state <= RUN;
                                enclk <= 3'b111;
                                ready <= 1'b1;
                            end else begin
                                enclk <= 3'b011;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    RUN: begin
                        if (!lock_s) begin
                            state     <= RESET;
                            cnt       <= '0;
                            enclk     <= 3'b000;
                            ready     <= 1'b0;
                            pll_reset <= 1'b1;
                            if (relock_cnt != 8'hFF) begin
                                relock_cnt <= relock_cnt + 8'd1;
                            end
                        end
                    end
                    FAULT: begin
                        if (!start) begin
                            state <= IDLE;
                            cnt   <= '0;
                            fail  <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        enclk     <= 3'b000;
                        ready     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pll_ddr_ctrl.md
PLL_DDR_CTRL -- requirements
Module: pll_ddr_ctrl

Interface
REQ-001 The block SHALL expose these parameters:
- RST_CYCLES, default 16: PLL reset pulse width in clkin cycles.
- LOCK_TIMEOUT, default 65535: cycles to wait for lock before timeout.
- SETTLE_CYCLES, default 256: consecutive cycles lock must stay high before clocks are enabled.
- EN_GAP, default 8: cycles between successive enclk bit enables.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset: clkin is the sole clock and resetn is the asynchronous active-low reset.
REQ-003 Ports (name, direction, width, meaning):
- clkin  in  1  reference clock, same as the PLL input clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  level request to bring up and hold the PLL outputs.
- pll_lock  in  1  PLL lock, asynchronous to clkin.
- pll_reset  out  1  drives the PLL reset input.
- enclk  out  3  drives PLL enclk2..enclk0.
- ready  out  1  all three outputs enabled and locked.
- fail  out  1  bring-up abandoned.
- relock_cnt  out  8  count of lock losses in RUN.

Function
REQ-004 pll_lock SHALL pass through a 2-flop synchronizer (lock_s); all decisions SHALL use lock_s, so lock response latency is 2 cycles.
REQ-005 All outputs SHALL be registered, with states IDLE, RESET, WAIT_LOCK, SETTLE, ENABLE, RUN and FAULT.
REQ-006 IDLE behaviour:
- pll_reset=1, enclk=0, ready=0.
- start=1 moves to RESET.
REQ-007 RESET behaviour:
- pll_reset=1 for exactly RST_CYCLES cycles.
- Then move to WAIT_LOCK with pll_reset=0.
REQ-008 WAIT_LOCK behaviour:
- Counter increments each cycle.
- lock_s=1 moves to SETTLE.
- When the counter reaches LOCK_TIMEOUT, a timeout event occurs (REQ-016).
REQ-009 SETTLE behaviour:
- lock_s must stay 1 for SETTLE_CYCLES consecutive cycles, then move to ENABLE.
- Any lock_s=0 returns to WAIT_LOCK with the timeout counter cleared.
REQ-010 ENABLE behaviour:
- Set enclk[0] on entry, then enclk[1] after EN_GAP cycles, then enclk[2] after another EN_GAP cycles.
- Move to RUN on the cycle enclk[2] is set.
- A lock_s drop during ENABLE SHALL clear enclk and return to RESET; relock_cnt does not change.
REQ-011 RUN behaviour:
- ready=1 and enclk=3'b111.
- lock_s=0 clears enclk and ready on the next edge, increments relock_cnt (saturating at 255) and moves to RESET.
REQ-012 start=0 in any state except FAULT SHALL move to IDLE on the next edge, clearing enclk and ready and asserting pll_reset. When start=0 and lock_s=0 occur in the same cycle, start takes priority and relock_cnt does not change.
REQ-013 FAULT behaviour:
- fail=1, pll_reset=1, enclk=0.
- Exit to IDLE only when start=0.
- fail clears on entry to IDLE.
REQ-014 All counters SHALL be wide enough for their parameter and SHALL clear on every state entry.

Reset
REQ-015 resetn=0 SHALL asynchronously force:
- state=IDLE, pll_reset=1, enclk=0, ready=0, fail=0, relock_cnt=0.
- All counters and synchronizer flops to 0.
Mid-sequence reset aborts immediately; after release, a new start=1 restarts from RESET.

Configuration
REQ-016 The macro PLL_DDR_CTRL_RETRY_EN controls timeout handling:
- Defined: a timeout increments an internal 2-bit retry count and returns to RESET. The third consecutive timeout moves to FAULT. The retry count clears on entry to RUN or IDLE.
- Undefined: the first timeout moves directly to FAULT and no retry logic exists.

Verification
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=8, EN_GAP=2.
REQ-017 Normal bring-up: start=1 and pll_lock rises 10 cycles after pll_reset falls -> pll_reset high for 4 cycles; enclk goes 001, then 011, then 111 at 2-cycle spacing; ready=1 alongside 111; relock_cnt=0.
REQ-018 Lock glitch in SETTLE: pll_lock low for 3 cycles after 5 settle cycles -> return to WAIT_LOCK; enclk stays 0 until 8 uninterrupted locked cycles.
REQ-019 Lock loss in RUN: pll_lock drops -> after sync latency, enclk=000 and ready=0; relock_cnt=1; a fresh 4-cycle pll_reset pulse.
REQ-020 Timeout: pll_lock held low -> with PLL_DDR_CTRL_RETRY_EN, three 4-cycle reset pulses then fail=1; without it, fail=1 after the first 100-cycle wait. Then start=0 -> IDLE with fail=0.
REQ-021 Simultaneous events: start=0 and pll_lock=0 in the same RUN cycle -> IDLE with relock_cnt unchanged. resetn pulsed low during ENABLE -> all outputs return to reset values immediately.
